// File: rtl/aes_word_loader.sv
// Packs a 32-bit key/data word stream into 128-bit blocks for the AES core and returns its result.
// Latency: core enabled 1 cycle after the 4th data word; result 1 cycle after core valid; held until out_ready (input stalls while busy).
module aes_word_loader #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 8
) (
    input  logic         AES_clk,
    input  logic         AES_rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  in_data,
    input  logic         in_is_key,
    output logic         core_en,
    output logic [127:0] core_data,
    output logic [127:0] core_key,
    input  logic [127:0] core_out,
    input  logic         core_out_valid,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy,
    output logic         err_timeout
);

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        RUN  = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [127:0]     key_sr;
    logic [127:0]     data_sr;
    logic [1:0]       dcnt;
    logic [CNT_W-1:0] rcnt;
    logic             accept;
    logic             data_last;
    logic             timeout_hit;

    assign accept      = in_valid && in_ready;
    assign data_last   = accept && !in_is_key && (dcnt == 2'd3);
    assign timeout_hit = (rcnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Shift registers feed the core directly; they cannot move outside LOAD.
    assign core_data = data_sr;
    assign core_key  = key_sr;
    assign busy      = (state != LOAD);

    always_ff @(posedge AES_clk or negedge AES_rst_n) begin
        if (!AES_rst_n) begin
            state <= LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            LOAD: begin
                if (data_last) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (core_out_valid || timeout_hit) begin
                    state_nxt = core_out_valid ? OUT : LOAD;
                end
            end
            OUT: begin
                if (out_ready) begin
                    state_nxt = LOAD;
                end
            end
            default: state_nxt = LOAD;
        endcase
    end

    always_ff @(posedge AES_clk or negedge AES_rst_n) begin
        if (!AES_rst_n) begin
            in_ready    <= 1'b0;
            key_sr      <= '0;
            data_sr     <= '0;
            dcnt        <= '0;
            rcnt        <= '0;
            core_en     <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            err_timeout <= 1'b0;
        end else begin
            // Registered ready tracks the upcoming state, so it drops on the 4th-word edge.
            in_ready <= (state_nxt == LOAD);

            if (accept) begin
                if (in_is_key) begin
                    key_sr <= {key_sr[95:0], in_data};
                end else begin
                    data_sr <= {data_sr[95:0], in_data};
                    dcnt    <= dcnt + 2'd1;
                end
            end

            case (state)
                LOAD: begin
                    if (data_last) begin
                        core_en <= 1'b1;
                    end
                end
                RUN: begin
                    if (core_out_valid) begin
                        out_data  <= core_out;
                        out_valid <= 1'b1;
                        core_en   <= 1'b0;
                        rcnt      <= '0;
                    end else if (timeout_hit) begin
                        err_timeout <= 1'b1;
                        core_en     <= 1'b0;
                        rcnt        <= '0;
                    end else begin
                        rcnt <= rcnt + 1'b1;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
